// File: rtl/lc3_memory_interface_pkg.sv
// Shared types and constants for the LC-3 MAR/MDR memory-interface stage.
package lc3_memory_interface_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int          DATA_W_DEF   = 16;
  localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

endpackage

// File: rtl/lc3_memory_interface_timeout.sv
// Wait-cycle counter for a pending memory access; cleared whenever en is low.
// expired marks the TIMEOUT-th consecutive enabled cycle; TIMEOUT=0 never expires.
module lc3_memory_interface_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic expired
);

  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count;

  // Saturates at LAST so a long wait can never wrap past the compare point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  assign expired = en && (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/lc3_memory_interface.sv
// LC-3 MAR/MDR stage: one ready/valid memory transaction per MIO_EN request, R pulses on completion.
// Request edge to R is at least 2 cycles; mem_req/addr/we/wdata are held stable until mem_ready or timeout.
module lc3_memory_interface
  import lc3_memory_interface_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                TIMEOUT  = 64,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] Bus,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              R_W,
  output logic [DATA_W-1:0] MAROut,
  output logic [DATA_W-1:0] MDROut,
  output logic              R,
  output logic              mem_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mar, mdr, rdata_q;
  logic              we_q, err_q, busy, expired;

  assign busy = (state == ST_READ) || (state == ST_WRITE);

  lc3_memory_interface_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (busy),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:           if (MIO_EN) state_nxt = R_W ? ST_WRITE : ST_READ;
      ST_READ, ST_WRITE: if (mem_ready || expired) state_nxt = ST_DONE;
      ST_DONE:           state_nxt = ST_IDLE;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar     <= '0;
      mdr     <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state == ST_IDLE && MIO_EN) begin
        we_q <= R_W;
      end
      // MAR drives mem_addr, so it is frozen while an access is pending.
      if (LD_MAR && (state == ST_IDLE || state == ST_DONE)) begin
        mar <= Bus;
      end
      if (LD_MDR && !MIO_EN && state != ST_WRITE) begin
        mdr <= Bus;
      end else if (LD_MDR && MIO_EN && state == ST_DONE && !we_q) begin
        mdr <= rdata_q;
      end
      // mem_ready wins over a timeout landing on the same edge.
      if (busy) begin
        err_q <= expired && !mem_ready;
      end
      if (state == ST_READ) begin
        if (mem_ready) begin
          rdata_q <= mem_rdata;
        end else if (expired) begin
          rdata_q <= ERR_DATA;
        end
      end
    end
  end

  assign MAROut    = mar;
  assign MDROut    = mdr;
  assign R         = (state == ST_DONE);
  assign mem_err   = (state == ST_DONE) && err_q;
  assign mem_req   = busy;
  assign mem_we    = busy && we_q;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;

endmodule
